// File: rtl/uart_tx_drain_pkg.sv
// Shared types and frame constants for the UART transmit-drain block.
package uart_tx_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;
  localparam int   FRAME_BITS           = 10;
  localparam int   DATA_BITS            = 8;
  localparam int   DEFAULT_CLKS_PER_BIT = 16;

  // Baud counter width; never below one bit so tiny divisors still elaborate.
  function automatic int cnt_width(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every frame starts on a fresh bit boundary.
module uart_baud_cnt
  import uart_tx_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CW = cnt_width(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from the transmit FIFO one frame at a time.
// Pop to start-bit is 2 cycles; a new frame only starts from IDLE with tx_enable set.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int            CW     = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] PENULT = CW'(CLKS_PER_BIT - 2);

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        bit_idx;
  logic              clear;
  logic              bit_end;
  logic [CW-1:0]     baud_count;

  // Counter is parked at zero until the start bit begins.
  assign clear = (state == ST_IDLE) || (state == ST_REQ) || (state == ST_LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .count  (baud_count),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      tx         <= STOP_BIT;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= STOP_BIT;
          if (tx_enable && !fifo_empty) begin
            state      <= ST_REQ;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_REQ: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_reg <= fifo_rd_data;
          bit_idx   <= '0;
          tx        <= START_BIT;
          state     <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[1];
            end
          end
        end
        ST_STOP: begin
          // Registered pulse lands on the final stop-bit cycle.
          if (baud_count == PENULT) begin
            tx_done <= 1'b1;
          end
          if (bit_end) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= STOP_BIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
